// File: rtl/serial_pattern_generator_pkg.sv
// Shared definitions for the serial pattern generator and the benches that
// pair it with the serial sequence detectors.
package pattern_gen_pkg;

    // Transmit FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Default pattern, matching the 6-bit detector it normally feeds
    localparam int                           DEFAULT_PATTERN_W = 6;
    localparam logic [DEFAULT_PATTERN_W-1:0] DEFAULT_PATTERN   = 6'b110011;

endpackage

// File: rtl/serial_pattern_generator_if.sv
// Request/stream bundle of the serial pattern generator. The master side
// issues requests and receives the serial stream; the slave side is the
// generator itself.
interface serial_pattern_generator_if #(
    parameter int REPS_W = 4
) ();

    logic              start;
    logic [REPS_W-1:0] reps;
    logic              hold;
    logic              ready;
    logic              a;
    logic              a_valid;
    logic              done;

    modport master (
        output start, reps, hold,
        input  ready, a, a_valid, done
    );

    modport slave (
        input  start, reps, hold,
        output ready, a, a_valid, done
    );

endinterface

// File: rtl/serial_pattern_generator.sv
// Serialises PATTERN onto a single line, MSB first, one bit per clock.
// A request repeats the pattern 'reps' times with GAP idle cycles between
// repetitions; 'hold' freezes progress without losing or repeating a bit.
// A one-cycle 'done' pulse closes every accepted request, including an
// empty one (reps == 0). Reset is synchronous and active-low.
module serial_pattern_generator
    import pattern_gen_pkg::*;
#(
    parameter int                   PATTERN_W = DEFAULT_PATTERN_W,
    parameter logic [PATTERN_W-1:0] PATTERN   = DEFAULT_PATTERN,
    parameter int                   GAP       = 2,
    parameter int                   REPS_W    = 4
) (
    input logic                       clk,
    input logic                       rst,
    serial_pattern_generator_if.slave bus
);

    localparam int BIT_IW = $clog2(PATTERN_W);
    localparam int GAP_CW = (GAP > 0) ? $clog2(GAP + 1) : 1;

    localparam logic [BIT_IW-1:0] BIT_MSB  = BIT_IW'(PATTERN_W - 1);
    localparam logic [GAP_CW-1:0] GAP_LOAD = GAP_CW'(GAP);
    localparam logic [REPS_W-1:0] REP_LAST = REPS_W'(1);

    state_t            state_q,   state_d;
    logic [BIT_IW-1:0] bit_idx_q, bit_idx_d;
    logic [GAP_CW-1:0] gap_cnt_q, gap_cnt_d;
    logic [REPS_W-1:0] rep_cnt_q, rep_cnt_d;
    logic              a_q,       a_d;
    logic              a_valid_q, a_valid_d;
    logic              done_q,    done_d;

    // Next-state and next-output decode; outputs default to an idle line so
    // every non-transmitting cycle (gap, stall, done, idle) drives a = 0.
    always_comb begin
        state_d   = state_q;
        bit_idx_d = bit_idx_q;
        gap_cnt_d = gap_cnt_q;
        rep_cnt_d = rep_cnt_q;
        a_d       = 1'b0;
        a_valid_d = 1'b0;
        done_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    if (bus.reps != '0) begin
                        state_d   = ST_SEND;
                        rep_cnt_d = bus.reps;
                        bit_idx_d = BIT_MSB;
                    end else begin
                        // Empty request still gets its completion pulse
                        state_d = ST_DONE;
                    end
                end
            end

            ST_SEND: begin
                if (!bus.hold) begin
                    a_d       = PATTERN[bit_idx_q];
                    a_valid_d = 1'b1;
                    if (bit_idx_q != '0) begin
                        bit_idx_d = bit_idx_q - 1'b1;
                    end else begin
                        // End of one repetition: rewind to the MSB for the next
                        bit_idx_d = BIT_MSB;
                        rep_cnt_d = rep_cnt_q - 1'b1;
                        if (rep_cnt_q == REP_LAST) begin
                            state_d = ST_DONE;
                        end else if (GAP > 0) begin
                            state_d   = ST_GAP;
                            gap_cnt_d = GAP_LOAD;
                        end else begin
                            state_d = ST_SEND;
                        end
                    end
                end
            end

            ST_GAP: begin
                if (!bus.hold) begin
                    gap_cnt_d = gap_cnt_q - 1'b1;
                    if (gap_cnt_q <= GAP_CW'(1)) begin
                        state_d = ST_SEND;
                    end
                end
            end

            ST_DONE: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counters and registered outputs; reset aborts any transfer
    // without producing a done pulse.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            bit_idx_q <= '0;
            gap_cnt_q <= '0;
            rep_cnt_q <= '0;
            a_q       <= 1'b0;
            a_valid_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_idx_q <= bit_idx_d;
            gap_cnt_q <= gap_cnt_d;
            rep_cnt_q <= rep_cnt_d;
            a_q       <= a_d;
            a_valid_q <= a_valid_d;
            done_q    <= done_d;
        end
    end

    assign bus.ready   = (state_q == ST_IDLE);
    assign bus.a       = a_q;
    assign bus.a_valid = a_valid_q;
    assign bus.done    = done_q;

endmodule

// File: tb/tb_serial_pattern_generator.sv
// Bench for serial_pattern_generator: two instances (GAP = 2 and GAP = 0)
// share one stimulus stream and are each compared cycle by cycle against a
// slot model: a transfer is the ordered list of output slots (pattern bits,
// gap slots, then the done slot), and every edge that is not stalled by
// hold consumes exactly one slot.
module tb_serial_pattern_generator;

    localparam int PW     = 6;
    localparam int REPS_W = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic [REPS_W-1:0] reps = '0;
    logic hold = 1'b0;

    bit [PW-1:0] pat_v = 6'b110011;

    int n_vec = 0;
    int n_err = 0;

    serial_pattern_generator_if #(.REPS_W(REPS_W)) bus2 ();
    serial_pattern_generator_if #(.REPS_W(REPS_W)) bus0 ();

    assign bus2.start = start;
    assign bus2.reps  = reps;
    assign bus2.hold  = hold;
    assign bus0.start = start;
    assign bus0.reps  = reps;
    assign bus0.hold  = hold;

    serial_pattern_generator #(
        .PATTERN_W(PW), .PATTERN(6'b110011), .GAP(2), .REPS_W(REPS_W)
    ) dut_gap2 (
        .clk(clk), .rst(rst), .bus(bus2.slave)
    );

    serial_pattern_generator #(
        .PATTERN_W(PW), .PATTERN(6'b110011), .GAP(0), .REPS_W(REPS_W)
    ) dut_gap0 (
        .clk(clk), .rst(rst), .bus(bus0.slave)
    );

    always #5 clk = ~clk;

    // Slot idx of a transfer of 'nr' repetitions with 'gap' idle slots
    // between repetitions; any idx past the last bit is the done slot.
    function automatic void model_slot(input int nr, input int gap, input int idx,
                                       output bit v, output bit b, output bit dn);
        int period, total, off;
        period = PW + gap;
        total  = (nr == 0) ? 0 : nr * PW + (nr - 1) * gap;
        v = 1'b0; b = 1'b0; dn = 1'b0;
        if (idx >= total) begin
            dn = 1'b1;
        end else begin
            off = idx % period;
            if (off < PW) begin
                v = 1'b1;
                b = pat_v[PW - 1 - off];
            end
        end
    endfunction

    // Issue one request and follow both instances until both are idle again.
    task automatic run_transfer(input string tag, input int nr, input int hold_pct,
                                input int hold_from, input int hold_len, input bit busy_start);
        int pos [2];
        bit fin [2];
        int extra;
        bit ov, oa, od, orr, ev, ea, ed, er, chk_r, sv, sb, sd;
        int g;
        pos[0] = 0; pos[1] = 0; fin[0] = 0; fin[1] = 0; extra = 0;

        start = 1'b1;
        reps  = REPS_W'(nr);
        hold  = 1'($urandom_range(1));
        @(posedge clk); #1;
        start = 1'b0;
        hold  = 1'b0;

        // Cycle right after acceptance: nothing on the line yet, busy
        for (int d = 0; d < 2; d++) begin
            if (d == 0) begin ov = bus2.a_valid; od = bus2.done; orr = bus2.ready; g = 2; end
            else        begin ov = bus0.a_valid; od = bus0.done; orr = bus0.ready; g = 0; end
            n_vec++;
            if (ov !== 1'b0 || od !== 1'b0 || orr !== 1'b0) begin
                n_err++;
                $display("FAIL %s accept gap%0d: a_valid/done/ready = %b%b%b, want 000",
                         tag, g, ov, od, orr);
            end
        end

        for (int e = 1; e <= 3000; e++) begin
            if (fin[0] && fin[1]) begin
                extra++;
                if (extra > 2) break;
            end
            hold  = (hold_from > 0 && e >= hold_from && e < hold_from + hold_len) ||
                    (int'($urandom_range(99)) < hold_pct);
            start = busy_start && !fin[0] && !fin[1] && 1'($urandom_range(1));
            reps  = REPS_W'($urandom);
            @(posedge clk); #1;

            for (int d = 0; d < 2; d++) begin
                if (d == 0) begin
                    ov = bus2.a_valid; oa = bus2.a; od = bus2.done; orr = bus2.ready; g = 2;
                end else begin
                    ov = bus0.a_valid; oa = bus0.a; od = bus0.done; orr = bus0.ready; g = 0;
                end
                model_slot(nr, g, pos[d], sv, sb, sd);
                chk_r = 1'b1;
                if (fin[d]) begin
                    ev = 0; ea = 0; ed = 0; er = 1;
                end else if (hold && !sd) begin
                    ev = 0; ea = 0; ed = 0; er = 0;
                end else begin
                    pos[d]++;
                    ev = sv; ea = sb; ed = sd; er = 0;
                    if (sd) begin
                        fin[d] = 1'b1;
                        chk_r  = 1'b0;
                    end
                end
                n_vec++;
                if (ov !== ev) begin
                    n_err++;
                    $display("FAIL %s a_valid gap%0d edge %0d: got %b want %b", tag, g, e, ov, ev);
                end
                n_vec++;
                if (oa !== ea) begin
                    n_err++;
                    $display("FAIL %s a gap%0d edge %0d: got %b want %b", tag, g, e, oa, ea);
                end
                n_vec++;
                if (od !== ed) begin
                    n_err++;
                    $display("FAIL %s done gap%0d edge %0d: got %b want %b", tag, g, e, od, ed);
                end
                if (chk_r) begin
                    n_vec++;
                    if (orr !== er) begin
                        n_err++;
                        $display("FAIL %s ready gap%0d edge %0d: got %b want %b", tag, g, e, orr, er);
                    end
                end
            end
        end
        start = 1'b0;
        hold  = 1'b0;
        n_vec++;
        if (!(fin[0] && fin[1])) begin
            n_err++;
            $display("FAIL %s timeout: done seen gap2=%b gap0=%b, want 11", tag, fin[0], fin[1]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b1; reps = 4'd5; hold = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if ({bus2.a, bus2.a_valid, bus2.done, bus2.ready} !== 4'b0001) begin
            n_err++;
            $display("FAIL reset gap2: a,a_valid,done,ready = %b%b%b%b, want 0001",
                     bus2.a, bus2.a_valid, bus2.done, bus2.ready);
        end
        n_vec++;
        if ({bus0.a, bus0.a_valid, bus0.done, bus0.ready} !== 4'b0001) begin
            n_err++;
            $display("FAIL reset gap0: a,a_valid,done,ready = %b%b%b%b, want 0001",
                     bus0.a, bus0.a_valid, bus0.done, bus0.ready);
        end
        start = 1'b0;
        rst   = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            n_vec++;
            if ({bus2.a_valid, bus2.done, bus2.ready, bus0.a_valid, bus0.done, bus0.ready} !== 6'b001001) begin
                n_err++;
                $display("FAIL reset_release: valid/done/ready gap2,gap0 = %b%b%b %b%b%b, want 001 001",
                         bus2.a_valid, bus2.done, bus2.ready, bus0.a_valid, bus0.done, bus0.ready);
            end
        end
    endtask

    task automatic test_single_rep();
        run_transfer("single_rep", 1, 0, 0, 0, 1'b0);
    endtask

    task automatic test_reps_with_gap();
        run_transfer("reps3", 3, 0, 0, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_transfer("reps2", 2, 0, 0, 0, 1'b0);
    endtask

    task automatic test_hold();
        run_transfer("hold3", 1, 0, 4, 3, 1'b0);
        run_transfer("hold_gap", 2, 0, 6, 2, 1'b0);
    endtask

    task automatic test_reps_zero();
        run_transfer("reps0", 0, 0, 0, 0, 1'b0);
    endtask

    task automatic test_max_reps();
        run_transfer("reps_max", 15, 0, 0, 0, 1'b0);
    endtask

    task automatic test_start_while_busy();
        run_transfer("busy_start", 2, 0, 0, 0, 1'b1);
    endtask

    task automatic test_reset_mid_send();
        start = 1'b1; reps = 4'd3; hold = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        n_vec++;
        if ({bus2.a, bus2.a_valid, bus2.done, bus2.ready, bus0.a, bus0.a_valid, bus0.done, bus0.ready} !== 8'b0001_0001) begin
            n_err++;
            $display("FAIL mid_reset: a,valid,done,ready gap2,gap0 = %b%b%b%b %b%b%b%b, want 0001 0001",
                     bus2.a, bus2.a_valid, bus2.done, bus2.ready, bus0.a, bus0.a_valid, bus0.done, bus0.ready);
        end
        repeat (8) begin
            @(posedge clk); #1;
            n_vec++;
            if ({bus2.a_valid, bus2.done, bus0.a_valid, bus0.done} !== 4'b0000) begin
                n_err++;
                $display("FAIL mid_reset_quiet: valid,done gap2,gap0 = %b%b %b%b, want 00 00",
                         bus2.a_valid, bus2.done, bus0.a_valid, bus0.done);
            end
        end
        run_transfer("after_reset", 1, 0, 0, 0, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 12; i++) begin
            run_transfer("random", int'($urandom_range(0, 15)), 25, 0, 0, 1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_single_rep();
        test_reps_with_gap();
        test_back_to_back();
        test_hold();
        test_reps_zero();
        test_max_reps();
        test_start_while_busy();
        test_reset_mid_send();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
